// File: rtl/output_drain_fifo_pkg.sv
// Shared constants for the output drain FIFO: default geometry and FSM state encodings.
package output_drain_fifo_pkg;

  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DRAIN = 2'b01,
    DONE  = 2'b10
  } drainStateT;

endpackage

// File: rtl/output_drain_fifo_fifo_ram.sv
// DEPTH x WIDTH register array: synchronous write port, asynchronous read port.
module fifo_ram
  import output_drain_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wrEn,
  input  logic [AW-1:0]    wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic [AW-1:0]    rdAddr,
  output logic [WIDTH-1:0] rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/output_drain_fifo.sv
// Buffers processor OUT words for a slower ready/valid sink and raises done once
// every word captured before halt has been drained.
module output_drain_fifo
  import output_drain_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_halt,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             done
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;
  drainStateT    state;
  logic          pop;
  logic          push;
  logic          accept;

  assign out_valid = (count != '0);
  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign accept    = (state == RUN);
  assign pop       = out_valid & out_ready;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign push      = in_valid & accept & (!full | pop);

  fifo_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) ram (
    .clock (clock),
    .wrEn  (push),
    .wrAddr(wrPtr),
    .wrData(in_data),
    .rdAddr(rdPtr),
    .rdData(out_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      state    <= RUN;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      // Words ignored after halt are not losses; only refused RUN-state words are.
      if (in_valid & accept & full & !pop) overflow <= 1'b1;

      case (state)
        RUN: begin
          if (in_halt) state <= DRAIN;
        end
        DRAIN: begin
          if ((count == '0) || ((count == {{AW{1'b0}}, 1'b1}) && pop)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
